i2c_slave: RTL and testbench

- Synthesizable I2C target (slave) that answers the bus transactions issued by the team's I2C master bench model.
- Oversamples SCL/SDA on the system clock and detects START, repeated START and STOP.
- Matches a fixed 7-bit address and ACKs it.
- Writes received bytes into an internal register file, or returns register bytes on reads, using an auto-incrementing pointer that resets to 0 at every START.
- A host-side port gives the local logic access to the same register file.

---
 rtl/i2c_slave_if.sv | 25 ++
 rtl/i2c_slave.sv | 109 ++++++++++
 tb/tb_i2c_slave.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_slave_if.sv
// i2c_slave_if: bus pins and host register port of the i2c_slave.
//   scl_i/sda_i: bus levels in; sda_o: open-drain drive (0 = pull low)
//   host_we/host_addr/host_wdata/host_rdata: local register file access
//   busy/addr_match/wr_strobe/wr_index: transaction status
interface i2c_slave_if #(parameter int PTR_W = 4);
  logic scl_i;
  logic sda_i;
  logic sda_o;
  logic host_we;
  logic [PTR_W-1:0] host_addr;
  logic [7:0] host_wdata;
  logic [7:0] host_rdata;
  logic busy;
  logic addr_match;
  logic wr_strobe;
  logic [PTR_W-1:0] wr_index;
  modport slave (
    input scl_i, sda_i, host_we, host_addr, host_wdata,
    output sda_o, host_rdata, busy, addr_match, wr_strobe, wr_index
  );
  modport master (
    output scl_i, sda_i, host_we, host_addr, host_wdata,
    input sda_o, host_rdata, busy, addr_match, wr_strobe, wr_index
  );
endinterface

// File: rtl/i2c_slave.sv
// i2c_slave: oversampled I2C target with auto-increment register file and host port.
//   clk/rst: system clock (>=20x SCL), synchronous active-high reset
//   bus: i2c_slave_if.slave (SCL/SDA pins, host port, status outputs)
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h42,
  parameter int PTR_W = 4
) (
  input logic clk,
  input logic rst,
  i2c_slave_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE} state_t;
  state_t state, state_n;
  logic scl_m, scl_s, scl_h, sda_m, sda_s, sda_h;
  logic [7:0] regs [2**PTR_W];
  logic [PTR_W-1:0] ptr, wr_index;
  logic [2:0] bit_cnt;
  logic [6:0] shift;
  logic [7:0] shadow;
  logic rw, ack_on, sda_o, busy, addr_match, wr_strobe;
  logic scl_rise, scl_fall, start, stop;
  assign scl_rise = scl_s & ~scl_h;
  assign scl_fall = ~scl_s & scl_h;
  assign start = scl_s & scl_h & sda_h & ~sda_s;
  assign stop = scl_s & scl_h & ~sda_h & sda_s;
  assign bus.sda_o = sda_o;
  assign bus.busy = busy;
  assign bus.addr_match = addr_match;
  assign bus.wr_strobe = wr_strobe;
  assign bus.wr_index = wr_index;
  assign bus.host_rdata = regs[bus.host_addr];
  always_ff @(posedge clk) begin
    if (rst) {scl_m, scl_s, scl_h, sda_m, sda_s, sda_h} <= '1;
    else {scl_m, scl_s, scl_h, sda_m, sda_s, sda_h} <= {bus.scl_i, scl_m, scl_s, bus.sda_i, sda_m, sda_s};
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  // ack_on marks the second half of an ACK slot: low already driven (or ACK seen on reads)
  always_comb begin
    state_n = state;
    if (start) state_n = ADDR;
    else if (stop) state_n = IDLE;
    else
      case (state)
        ADDR:     if (scl_rise && bit_cnt == 3'd7) state_n = (shift == SLAVE_ADDR) ? ADDR_ACK : IGNORE;
        ADDR_ACK: if (scl_fall && ack_on) state_n = rw ? RD_DATA : WR_DATA;
        WR_DATA:  if (scl_rise && bit_cnt == 3'd7) state_n = WR_ACK;
        WR_ACK:   if (scl_fall && ack_on) state_n = WR_DATA;
        RD_DATA:  if (scl_fall && bit_cnt == 3'd7) state_n = RD_ACK;
        RD_ACK:   state_n = (scl_rise && sda_s) ? IGNORE : (scl_fall && ack_on) ? RD_DATA : RD_ACK;
        default:  state_n = state;
      endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**PTR_W; i++) regs[i] <= 8'h00;
      {sda_o, busy, addr_match, wr_strobe, rw, ack_on} <= 6'b100000;
      {ptr, wr_index, bit_cnt, shift, shadow} <= '0;
    end else begin
      wr_strobe <= 1'b0;
      if (bus.host_we) regs[bus.host_addr] <= bus.host_wdata;
      if (start) begin
        {bit_cnt, ptr, ack_on, addr_match} <= '0;
        {busy, sda_o} <= 2'b11;
      end else if (stop) begin
        {busy, addr_match, ack_on} <= '0;
        sda_o <= 1'b1;
      end else
        case (state)
          ADDR, WR_DATA:
            if (scl_rise) begin
              shift <= {shift[5:0], sda_s};
              bit_cnt <= bit_cnt + 3'd1;
              ack_on <= 1'b0;
              if (bit_cnt == 3'd7 && state == ADDR) rw <= sda_s;
              if (bit_cnt == 3'd7 && state == WR_DATA) begin
                regs[ptr] <= {shift, sda_s};
                wr_strobe <= 1'b1;
                wr_index <= ptr;
                ptr <= ptr + 1'b1;
              end
            end
          ADDR_ACK, WR_ACK, RD_ACK:
            if (scl_rise && state == RD_ACK) ack_on <= ~sda_s;
            else if (scl_fall && !ack_on && state != RD_ACK) begin
              sda_o <= 1'b0;
              ack_on <= 1'b1;
              if (state == ADDR_ACK) addr_match <= 1'b1;
            end else if (scl_fall && ack_on) begin
              ack_on <= 1'b0;
              bit_cnt <= 3'd0;
              // Read bytes are latched into a shadow so host writes cannot tear them
              if (state == RD_ACK || (state == ADDR_ACK && rw)) begin
                shadow <= regs[ptr];
                sda_o <= regs[ptr][7];
                ptr <= ptr + 1'b1;
              end else sda_o <= 1'b1;
            end
          RD_DATA:
            if (scl_fall) begin
              bit_cnt <= bit_cnt + 3'd1;
              sda_o <= (bit_cnt == 3'd7) ? 1'b1 : shadow[6];
              shadow <= {shadow[6:0], 1'b0};
              ack_on <= 1'b0;
            end
          default: sda_o <= 1'b1;
        endcase
    end
  end
endmodule

// File: tb/tb_i2c_slave.sv
// tb_i2c_slave: bit-banged I2C master with scoreboards for read data and write strobes.
module tb_i2c_slave;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m_sda = 1'b1;
  always #5 clk = ~clk;
  i2c_slave_if #(.PTR_W(4)) bus();
  assign bus.sda_i = m_sda & bus.sda_o;
  i2c_slave #(.SLAVE_ADDR(7'h42), .PTR_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  int vectors = 0;
  int miscompares = 0;
  int low_cnt = 0;
  int am_cnt = 0;
  int stb_cnt = 0;
  logic [3:0] idx_log [256];
  logic [7:0] rd_q [$];
  logic [3:0] wr_q [$];
  always @(negedge clk) begin
    if (bus.sda_o === 1'b0) low_cnt++;
    if (bus.addr_match === 1'b1) am_cnt++;
    if (bus.wr_strobe === 1'b1) begin
      if (stb_cnt < 256) idx_log[stb_cnt] = bus.wr_index;
      stb_cnt++;
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic qw(input int n = 1);
    repeat (n * 10) @(negedge clk);
  endtask
  task automatic i2c_start;
    m_sda = 1'b1; qw(); bus.scl_i = 1'b1; qw(); m_sda = 1'b0; qw(); bus.scl_i = 1'b0; qw();
  endtask
  task automatic i2c_stop;
    m_sda = 1'b0; qw(); bus.scl_i = 1'b1; qw(); m_sda = 1'b1; qw();
  endtask
  task automatic put_bit(input logic b);
    m_sda = b; qw(); bus.scl_i = 1'b1; qw(2); bus.scl_i = 1'b0; qw();
  endtask
  task automatic get_bit(output logic b);
    m_sda = 1'b1; qw(); bus.scl_i = 1'b1; qw(); b = bus.sda_i; qw(); bus.scl_i = 1'b0; qw();
  endtask
  task automatic put_byte(input logic [7:0] d, output logic acked);
    logic b;
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(b);
    acked = ~b;
  endtask
  task automatic get_byte(output logic [7:0] d, input logic nack);
    for (int i = 7; i >= 0; i--) get_bit(d[i]);
    put_bit(nack);
  endtask
  task automatic host_write(input logic [3:0] a, input logic [7:0] d);
    bus.host_addr = a; bus.host_wdata = d; bus.host_we = 1'b1;
    @(negedge clk);
    bus.host_we = 1'b0;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++; if (bus.sda_o !== 1'b1) begin miscompares++; $display("FAIL reset_sda_o: got %b want 1", bus.sda_o); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    vectors++; if (bus.addr_match !== 1'b0) begin miscompares++; $display("FAIL reset_addr_match: got %b want 0", bus.addr_match); end
    vectors++; if (bus.wr_strobe !== 1'b0) begin miscompares++; $display("FAIL reset_wr_strobe: got %b want 0", bus.wr_strobe); end
    vectors++; if (bus.wr_index !== 4'd0) begin miscompares++; $display("FAIL reset_wr_index: got %h want 0", bus.wr_index); end
    for (int i = 0; i < 16; i++) begin
      bus.host_addr = 4'(i);
      @(negedge clk);
      vectors++; if (bus.host_rdata !== 8'h00) begin miscompares++; $display("FAIL reset_reg[%0d]: got %h want 00", i, bus.host_rdata); end
    end
  endtask
  task automatic test_write1;
    logic a;
    int s0 = stb_cnt;
    int k = 0;
    logic [3:0] e;
    i2c_start;
    vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL w1_busy_start: got %b want 1", bus.busy); end
    put_byte(8'h84, a);
    vectors++; if (a !== 1'b1) begin miscompares++; $display("FAIL w1_addr_ack: got %b want 1", a); end
    vectors++; if (bus.addr_match !== 1'b1) begin miscompares++; $display("FAIL w1_addr_match: got %b want 1", bus.addr_match); end
    wr_q.push_back(4'd0);
    put_byte(8'hA5, a);
    vectors++; if (a !== 1'b1) begin miscompares++; $display("FAIL w1_data_ack: got %b want 1", a); end
    i2c_stop;
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL w1_busy_stop: got %b want 0", bus.busy); end
    vectors++; if (bus.addr_match !== 1'b0) begin miscompares++; $display("FAIL w1_match_stop: got %b want 0", bus.addr_match); end
    vectors++; if (stb_cnt - s0 !== wr_q.size()) begin miscompares++; $display("FAIL w1_strobes: got %0d want %0d", stb_cnt - s0, wr_q.size()); end
    while (wr_q.size() > 0) begin
      e = wr_q.pop_front();
      vectors++; if (idx_log[s0 + k] !== e) begin miscompares++; $display("FAIL w1_wr_index[%0d]: got %h want %h", k, idx_log[s0 + k], e); end
      k++;
    end
    bus.host_addr = 4'd0;
    @(negedge clk);
    vectors++; if (bus.host_rdata !== 8'hA5) begin miscompares++; $display("FAIL w1_reg0: got %h want a5", bus.host_rdata); end
  endtask
  task automatic test_write_read;
    logic a;
    logic [7:0] d, e;
    logic [7:0] pat [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    int s0 = stb_cnt;
    i2c_start;
    put_byte(8'h84, a);
    vectors++; if (a !== 1'b1) begin miscompares++; $display("FAIL wr_addr_ack: got %b want 1", a); end
    for (int i = 0; i < 4; i++) begin
      wr_q.push_back(4'(i));
      put_byte(pat[i], a);
      vectors++; if (a !== 1'b1) begin miscompares++; $display("FAIL wr_data_ack[%0d]: got %b want 1", i, a); end
    end
    i2c_start;
    put_byte(8'h85, a);
    vectors++; if (a !== 1'b1) begin miscompares++; $display("FAIL rd_addr_ack: got %b want 1", a); end
    for (int i = 0; i < 4; i++) begin
      rd_q.push_back(pat[i]);
      get_byte(d, i == 3);
      e = rd_q.pop_front();
      vectors++; if (d !== e) begin miscompares++; $display("FAIL rd_data[%0d]: got %h want %h", i, d, e); end
    end
    i2c_stop;
    vectors++; if (stb_cnt - s0 !== 4) begin miscompares++; $display("FAIL wr_strobes: got %0d want 4", stb_cnt - s0); end
    for (int k = 0; wr_q.size() > 0; k++) begin
      logic [3:0] x;
      x = wr_q.pop_front();
      vectors++; if (idx_log[s0 + k] !== x) begin miscompares++; $display("FAIL wr_index[%0d]: got %h want %h", k, idx_log[s0 + k], x); end
    end
  endtask
  task automatic test_mismatch;
    logic a;
    int l0 = low_cnt;
    int a0 = am_cnt;
    int s0 = stb_cnt;
    i2c_start;
    put_byte(8'h86, a);
    vectors++; if (a !== 1'b0) begin miscompares++; $display("FAIL mm_addr_ack: got %b want 0", a); end
    put_byte(8'h99, a);
    i2c_stop;
    vectors++; if (low_cnt !== l0) begin miscompares++; $display("FAIL mm_sda_low: got %0d want %0d", low_cnt - l0, 0); end
    vectors++; if (am_cnt !== a0) begin miscompares++; $display("FAIL mm_addr_match: got %0d want 0", am_cnt - a0); end
    vectors++; if (stb_cnt !== s0) begin miscompares++; $display("FAIL mm_strobes: got %0d want 0", stb_cnt - s0); end
    bus.host_addr = 4'd0;
    @(negedge clk);
    vectors++; if (bus.host_rdata !== 8'h11) begin miscompares++; $display("FAIL mm_reg0: got %h want 11", bus.host_rdata); end
    i2c_start;
    put_byte(8'h84, a);
    vectors++; if (a !== 1'b1) begin miscompares++; $display("FAIL mm_next_ack: got %b want 1", a); end
    i2c_stop;
  endtask
  task automatic test_wrap;
    logic a;
    int s0 = stb_cnt;
    i2c_start;
    put_byte(8'h84, a);
    for (int i = 0; i < 17; i++) begin
      wr_q.push_back(4'(i));
      put_byte(8'(i), a);
      vectors++; if (a !== 1'b1) begin miscompares++; $display("FAIL wrap_ack[%0d]: got %b want 1", i, a); end
    end
    i2c_stop;
    vectors++; if (stb_cnt - s0 !== 17) begin miscompares++; $display("FAIL wrap_strobes: got %0d want 17", stb_cnt - s0); end
    for (int k = 0; wr_q.size() > 0; k++) begin
      logic [3:0] x;
      x = wr_q.pop_front();
      vectors++; if (idx_log[s0 + k] !== x) begin miscompares++; $display("FAIL wrap_index[%0d]: got %h want %h", k, idx_log[s0 + k], x); end
    end
    for (int i = 0; i < 16; i++) begin
      bus.host_addr = 4'(i);
      @(negedge clk);
      vectors++; if (bus.host_rdata !== ((i == 0) ? 8'h10 : 8'(i))) begin miscompares++; $display("FAIL wrap_reg[%0d]: got %h want %h", i, bus.host_rdata, (i == 0) ? 8'h10 : 8'(i)); end
    end
  endtask
  task automatic test_read_nack;
    logic a, b;
    logic [7:0] d, e;
    int l0;
    host_write(4'd0, 8'h5A);
    host_write(4'd1, 8'hC3);
    i2c_start;
    put_byte(8'h85, a);
    vectors++; if (a !== 1'b1) begin miscompares++; $display("FAIL nack_addr_ack: got %b want 1", a); end
    rd_q.push_back(8'h5A);
    get_byte(d, 1'b1);
    e = rd_q.pop_front();
    vectors++; if (d !== e) begin miscompares++; $display("FAIL nack_data: got %h want %h", d, e); end
    l0 = low_cnt;
    get_bit(b);
    get_bit(b);
    i2c_stop;
    vectors++; if (low_cnt !== l0) begin miscompares++; $display("FAIL nack_released: got %0d low cycles want 0", low_cnt - l0); end
    bus.host_addr = 4'd1;
    @(negedge clk);
    vectors++; if (bus.host_rdata !== 8'hC3) begin miscompares++; $display("FAIL nack_reg1: got %h want c3", bus.host_rdata); end
  endtask
  task automatic test_reset_mid_read;
    logic a, b;
    int l0;
    host_write(4'd0, 8'hE0);
    i2c_start;
    put_byte(8'h85, a);
    for (int i = 0; i < 3; i++) get_bit(b);
    vectors++; if (bus.sda_o !== 1'b0) begin miscompares++; $display("FAIL mid_bit3_drive: got %b want 0", bus.sda_o); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++; if (bus.sda_o !== 1'b1) begin miscompares++; $display("FAIL mid_sda_release: got %b want 1", bus.sda_o); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL mid_busy: got %b want 0", bus.busy); end
    bus.host_addr = 4'd0;
    @(negedge clk);
    vectors++; if (bus.host_rdata !== 8'h00) begin miscompares++; $display("FAIL mid_reg0: got %h want 00", bus.host_rdata); end
    l0 = low_cnt;
    for (int i = 0; i < 6; i++) get_bit(b);
    vectors++; if (low_cnt !== l0) begin miscompares++; $display("FAIL mid_idle: got %0d low cycles want 0", low_cnt - l0); end
    vectors++; if (bus.addr_match !== 1'b0) begin miscompares++; $display("FAIL mid_addr_match: got %b want 0", bus.addr_match); end
    i2c_stop;
    i2c_start;
    put_byte(8'h84, a);
    vectors++; if (a !== 1'b1) begin miscompares++; $display("FAIL mid_restart_ack: got %b want 1", a); end
    put_byte(8'h77, a);
    i2c_stop;
    @(negedge clk);
    vectors++; if (bus.host_rdata !== 8'h77) begin miscompares++; $display("FAIL mid_restart_reg0: got %h want 77", bus.host_rdata); end
  endtask
  initial begin
    bus.scl_i = 1'b1;
    bus.host_we = 1'b0;
    bus.host_addr = '0;
    bus.host_wdata = '0;
    test_reset;
    test_write1;
    test_write_read;
    test_mismatch;
    test_wrap;
    test_read_nack;
    test_reset_mid_read;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
